sqrt_pipe_hs: RTL

- Parametrised, fully pipelined unsigned square-root unit. It is the next generation of the team's fixed 16-bit pipelined sqrt.
- Uses exact digit-recurrence (restoring), one result bit per sub-stage, so results are bit-exact and can be checked against a golden model.
- Adds a valid/ready handshake with backpressure, a tag passthrough and an exact-square flag.
- Sits between the fixed-point datapath producer and any consumer of Q(WIDTH/2).OUT_FW magnitudes.

---
 rtl/sqrt_pipe_pkg.sv | 18 +
 rtl/sqrt_rec_step.sv | 25 ++
 rtl/sqrt_pipe_hs.sv | 105 ++++++++++
 3 files changed

// File: rtl/sqrt_pipe_pkg.sv
// sqrt_pipe_pkg: width and latency helpers shared by the
// pipelined square-root unit and its recurrence step.
package sqrt_pipe_pkg;

  function automatic int res_w(input int width, input int out_fw);
    return width / 2 + out_fw;
  endfunction

  function automatic int rem_w(input int width, input int out_fw);
    return res_w(width, out_fw) + 2;
  endfunction

  function automatic int lat(input int width, input int out_fw,
                             input int bps);
    return res_w(width, out_fw) / bps;
  endfunction

endpackage

// File: rtl/sqrt_rec_step.sv
// sqrt_rec_step: one restoring digit-recurrence step,
// consuming one radicand bit pair and producing one root bit.
module sqrt_rec_step #(
  parameter int R  = 14,
  parameter int RW = R + 2
) (
  input  logic [R-1:0]  i_q,
  input  logic [RW-1:0] i_r,
  input  logic [1:0]    i_pair,
  output logic [R-1:0]  o_q,
  output logic [RW-1:0] o_r
);

  logic [RW-1:0] w_rs;
  logic [RW-1:0] w_t;
  logic          w_ge;

  // remainder never needs more than RW bits, so the top pair drops
  assign w_rs = RW'({i_r, i_pair});
  assign w_t  = {i_q, 2'b01};
  assign w_ge = (w_rs >= w_t);
  assign o_r  = w_ge ? (w_rs - w_t) : w_rs;
  assign o_q  = R'({i_q, w_ge});

endmodule

// File: rtl/sqrt_pipe_hs.sv
// sqrt_pipe_hs: pipelined restoring sqrt with valid/ready, tag and
// exact flag. Define SQRT_PIPE_ROUND_EN for round-to-nearest output.
module sqrt_pipe_hs
  import sqrt_pipe_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int OUT_FW         = 6,
  parameter int BITS_PER_STAGE = 1,
  parameter int TAG_W          = 4,
  localparam int R = res_w(WIDTH, OUT_FW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] N,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [R-1:0]     sqrt,
  output logic             out_exact,
  output logic [TAG_W-1:0] out_tag
);

  localparam int RW  = rem_w(WIDTH, OUT_FW);
  localparam int L   = lat(WIDTH, OUT_FW, BITS_PER_STAGE);
  localparam int XW  = 2 * R;
  localparam int BPS = BITS_PER_STAGE;

  if (WIDTH % 2 != 0) begin : g_err_width
    $error("sqrt_pipe_hs: WIDTH must be even");
  end
  if (R % BPS != 0) begin : g_err_bps
    $error("sqrt_pipe_hs: BITS_PER_STAGE must divide R");
  end

  typedef struct packed {
    logic             v;
    logic [R-1:0]     q;
    logic [RW-1:0]    r;
    logic [XW-1:0]    x;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t        r_st  [L];
  stage_t        w_nxt [L];
  logic          w_adv;
  logic [XW-1:0] w_x0;

  // one global advance: a stalled output freezes the whole pipe
  assign w_adv    = !r_st[L-1].v || out_ready;
  assign in_ready = w_adv;
  assign w_x0     = XW'(N) << (2 * OUT_FW);

  for (genvar s = 0; s < L; s++) begin : g_st
    stage_t        w_in;
    logic [R-1:0]  w_q [BPS+1];
    logic [RW-1:0] w_r [BPS+1];

    if (s == 0) begin : g_src
      assign w_in = '{v: in_valid, q: '0, r: '0,
                      x: w_x0, tag: in_tag};
    end else begin : g_src
      assign w_in = r_st[s-1];
    end

    assign w_q[0] = w_in.q;
    assign w_r[0] = w_in.r;

    for (genvar j = 0; j < BPS; j++) begin : g_sub
      sqrt_rec_step #(.R(R), .RW(RW)) u_step (
        .i_q    (w_q[j]),
        .i_r    (w_r[j]),
        .i_pair (w_in.x[XW-1-2*j -: 2]),
        .o_q    (w_q[j+1]),
        .o_r    (w_r[j+1])
      );
    end

    assign w_nxt[s] = '{v: w_in.v, q: w_q[BPS], r: w_r[BPS],
                        x: w_in.x << (2 * BPS), tag: w_in.tag};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < L; s++) r_st[s] <= '0;
    end else if (w_adv) begin
      for (int s = 0; s < L; s++) r_st[s] <= w_nxt[s];
    end
  end

  assign out_valid = r_st[L-1].v;
  assign out_tag   = r_st[L-1].tag;
  assign out_exact = r_st[L-1].v && (r_st[L-1].r == '0);

`ifdef SQRT_PIPE_ROUND_EN
  logic w_up;
  // r > q means X lies above (q+0.5)^2; all-ones q saturates
  assign w_up = (r_st[L-1].r > RW'(r_st[L-1].q)) && !(&r_st[L-1].q);
  assign sqrt = r_st[L-1].q + R'(w_up);
`else
  assign sqrt = r_st[L-1].q;
`endif

endmodule
